// File: rtl/reg_writeback_stage.sv
// Writeback stage: accepts one retiring instruction per cycle, waits for
// variable-latency load data, extracts/extends the loaded value and drives
// the registered register-file write port (also the forwarding source).
module reg_writeback_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 4,
    parameter int unsigned LINK_REG = 15,
    parameter int unsigned PC_INC   = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // Memory-access stage handshake and instruction fields
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_isWb,
    input  logic              in_isLd,
    input  logic              in_isCall,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_aluResult,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [1:0]        in_ldSize,
    input  logic              in_ldSigned,
    input  logic [1:0]        in_ldOff,
    // Load data return
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    // Register-file write port
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_wa,
    output logic [DATA_W-1:0] reg_wd,
    // Status
    output logic              ld_unexpected,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef enum logic [0:0] {
        StIdle,
        StWaitLd
    } state_e;

    state_e state_q, state_d;

    // Fields of a load parked while its data is outstanding
    logic              wb_q;
    logic [REG_AW-1:0] rd_q;
    logic [1:0]        ld_size_q;
    logic              ld_signed_q;
    logic [1:0]        ld_off_q;

    logic              accept;
    logic              latch_en;
    logic              commit;
    logic              we_d;
    logic [REG_AW-1:0] wa_d;
    logic [DATA_W-1:0] wd_d;
    logic              unexp_d;
    logic [DATA_W-1:0] call_wd;
    logic [REG_AW-1:0] link_wa;

    // Byte/half/word selection by low address bits, then sign or zero extension.
    // Size 3 falls through to word; for a half only bit 1 of the offset matters.
    function automatic logic [DATA_W-1:0] ld_extract(
        input logic [DATA_W-1:0] data,
        input logic [1:0]        size,
        input logic              sgn,
        input logic [1:0]        off
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = data[{off, 3'b000} +: 8];
        h = data[{off[1], 4'b0000} +: 16];
        case (size)
            2'd0:    r = {{(DATA_W - 8){sgn & b[7]}}, b};
            2'd1:    r = {{(DATA_W - 16){sgn & h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid && in_ready;
    assign call_wd  = in_pc + DATA_W'(PC_INC);
    assign link_wa  = REG_AW'(LINK_REG);

    // Next-state, result select and commit decision
    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        commit   = 1'b0;
        we_d     = 1'b0;
        wa_d     = reg_wa;
        wd_d     = reg_wd;
        unexp_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (in_isCall) begin
                        // A call wins over a load flag: no wait, ld_valid untouched
                        commit  = 1'b1;
                        we_d    = in_isWb;
                        wa_d    = link_wa;
                        wd_d    = call_wd;
                        unexp_d = ld_valid;
                    end else if (in_isLd) begin
                        if (ld_valid) begin
                            commit = 1'b1;
                            we_d   = in_isWb;
                            wa_d   = in_rd;
                            wd_d   = ld_extract(ld_data, in_ldSize, in_ldSigned, in_ldOff);
                        end else begin
                            latch_en = 1'b1;
                            state_d  = StWaitLd;
                        end
                    end else begin
                        commit  = 1'b1;
                        we_d    = in_isWb;
                        wa_d    = in_rd;
                        wd_d    = in_aluResult;
                        unexp_d = ld_valid;
                    end
                end else begin
                    unexp_d = ld_valid;
                end
            end
            StWaitLd: begin
                if (ld_valid) begin
                    commit  = 1'b1;
                    we_d    = wb_q;
                    wa_d    = rd_q;
                    wd_d    = ld_extract(ld_data, ld_size_q, ld_signed_q, ld_off_q);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state plus registered write port, status pulse and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            reg_we        <= 1'b0;
            reg_wa        <= '0;
            reg_wd        <= '0;
            ld_unexpected <= 1'b0;
            retire_cnt    <= '0;
        end else begin
            state_q       <= state_d;
            reg_we        <= we_d;
            reg_wa        <= wa_d;
            reg_wd        <= wd_d;
            ld_unexpected <= unexp_d;
            if (commit) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    // Park the load's destination and extraction controls while data is pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q        <= 1'b0;
            rd_q        <= '0;
            ld_size_q   <= 2'd0;
            ld_signed_q <= 1'b0;
            ld_off_q    <= 2'd0;
        end else if (latch_en) begin
            wb_q        <= in_isWb;
            rd_q        <= in_rd;
            ld_size_q   <= in_ldSize;
            ld_signed_q <= in_ldSigned;
            ld_off_q    <= in_ldOff;
        end
    end

endmodule

// File: tb/tb_reg_writeback_stage.sv
// Directed bench for reg_writeback_stage: table of single-cycle retirements
// plus hand-written sequences for load wait, back-to-back, unexpected data,
// reset mid-load and counter wrap (second instance with a 4-bit counter).
module tb_reg_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_isWb, in_isLd, in_isCall, in_ldSigned, ld_valid;
    logic [3:0]  in_rd;
    logic [31:0] in_aluResult, in_pc, ld_data;
    logic [1:0]  in_ldSize, in_ldOff;

    logic        in_ready, reg_we, ld_unexpected;
    logic [3:0]  reg_wa;
    logic [31:0] reg_wd, retire_cnt;

    logic        in_ready4, reg_we4, ld_unexpected4;
    logic [3:0]  reg_wa4;
    logic [31:0] reg_wd4;
    logic [3:0]  retire_cnt4;

    always #5 clk = ~clk;

    reg_writeback_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_isWb(in_isWb), .in_isLd(in_isLd), .in_isCall(in_isCall),
        .in_rd(in_rd), .in_aluResult(in_aluResult), .in_pc(in_pc),
        .in_ldSize(in_ldSize), .in_ldSigned(in_ldSigned), .in_ldOff(in_ldOff),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .reg_we(reg_we), .reg_wa(reg_wa), .reg_wd(reg_wd),
        .ld_unexpected(ld_unexpected), .retire_cnt(retire_cnt)
    );

    reg_writeback_stage #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_isWb(in_isWb), .in_isLd(in_isLd), .in_isCall(in_isCall),
        .in_rd(in_rd), .in_aluResult(in_aluResult), .in_pc(in_pc),
        .in_ldSize(in_ldSize), .in_ldSigned(in_ldSigned), .in_ldOff(in_ldOff),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .reg_we(reg_we4), .reg_wa(reg_wa4), .reg_wd(reg_wd4),
        .ld_unexpected(ld_unexpected4), .retire_cnt(retire_cnt4)
    );

    typedef struct {
        logic        wb, ld, call;
        logic [3:0]  rd;
        logic [31:0] alu, pc;
        logic [1:0]  sz;
        logic        sgn;
        logic [1:0]  off;
        logic        ldv;
        logic [31:0] ldd;
        logic        exp_we;
        logic [3:0]  exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [12];
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_isWb = 1'b0; in_isLd = 1'b0; in_isCall = 1'b0;
        in_rd = 4'd0; in_aluResult = 32'h0; in_pc = 32'h0;
        in_ldSize = 2'd0; in_ldSigned = 1'b0; in_ldOff = 2'd0;
        ld_valid = 1'b0; ld_data = 32'h0;
    endtask

    task automatic drive_alu(input logic [3:0] rd, input logic [31:0] alu);
        idle_inputs();
        in_valid = 1'b1; in_isWb = 1'b1; in_rd = rd; in_aluResult = alu;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    // Byte load at offset 2 whose data arrives three cycles after accept
    task automatic wait_load(input string tag, input logic sgn, input logic [31:0] exp_wd);
        idle_inputs();
        in_valid = 1'b1; in_isWb = 1'b1; in_isLd = 1'b1; in_rd = 4'd13;
        in_ldSize = 2'd0; in_ldSigned = sgn; in_ldOff = 2'd2;
        ld_data = 32'hFFFF_FFFF;
        tick();
        // Unrelated op held on the input: must not be accepted while waiting
        drive_alu(4'd1, 32'h0000_0BAD);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s_ready_w%0d", tag, c), in_ready, 0);
            chk($sformatf("%s_we_w%0d", tag, c), reg_we, 0);
            if (c < 2) tick();
        end
        ld_valid = 1'b1; ld_data = 32'h0080_0000;
        tick();
        idle_inputs();
        exp_cnt++;
        chk({tag, "_we"}, reg_we, 1);
        chk({tag, "_wa"}, reg_wa, 13);
        chk({tag, "_wd"}, reg_wd, exp_wd);
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_unexp"}, ld_unexpected, 0);
        chk({tag, "_cnt"}, retire_cnt, exp_cnt);
        tick();
        chk({tag, "_we_after"}, reg_we, 0);
        chk({tag, "_wd_hold"}, reg_wd, exp_wd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        //          wb    ld    call  rd     alu           pc            sz    sgn   off   ldv   ldd           we    wa     wd
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd3,  32'h0000_1234, 32'h0,       2'd0, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 4'd3,  32'h0000_1234};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'd7,  32'h0000_AAAA, 32'h100,     2'd0, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 4'd15, 32'h0000_0104};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'd7,  32'h0000_5555, 32'h200,     2'd0, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 4'd15, 32'h0000_0204};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd5,  32'h0,         32'h0,       2'd1, 1'b0, 2'd2, 1'b1, 32'h8001_0000, 1'b1, 4'd5,  32'h0000_8001};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'd6,  32'h0,         32'h0,       2'd1, 1'b1, 2'd3, 1'b1, 32'h8001_0000, 1'b1, 4'd6,  32'hFFFF_8001};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'd4,  32'h0,         32'h0,       2'd0, 1'b1, 2'd1, 1'b1, 32'h0000_7F00, 1'b1, 4'd4,  32'h0000_007F};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'd8,  32'h0,         32'h0,       2'd0, 1'b0, 2'd3, 1'b1, 32'hAB00_0000, 1'b1, 4'd8,  32'h0000_00AB};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'd9,  32'h0,         32'h0,       2'd2, 1'b1, 2'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 4'd9,  32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd10, 32'h0,         32'h0,       2'd3, 1'b1, 2'd0, 1'b1, 32'h1357_9BDF, 1'b1, 4'd10, 32'h1357_9BDF};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'd11, 32'h0,         32'h1000,    2'd2, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 4'd15, 32'h0000_1004};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd2,  32'h0000_0077, 32'h0,       2'd0, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 4'd2,  32'h0000_0077};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 4'd12, 32'h0,         32'h0,       2'd0, 1'b1, 2'd0, 1'b1, 32'h0000_00F0, 1'b1, 4'd12, 32'hFFFF_FFF0};

        // Reset held with a valid instruction presented
        drive_alu(4'd3, 32'h0000_9999);
        rst_n = 1'b0;
        #1;
        chk("rst_ready_now", in_ready, 1);
        tick();
        tick();
        chk("rst_we", reg_we, 0);
        chk("rst_wa", reg_wa, 0);
        chk("rst_wd", reg_wd, 0);
        chk("rst_unexp", ld_unexpected, 0);
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;

        // Single-cycle retirements, applied back to back
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            in_valid = 1'b1;
            in_isWb = vecs[i].wb; in_isLd = vecs[i].ld; in_isCall = vecs[i].call;
            in_rd = vecs[i].rd; in_aluResult = vecs[i].alu; in_pc = vecs[i].pc;
            in_ldSize = vecs[i].sz; in_ldSigned = vecs[i].sgn; in_ldOff = vecs[i].off;
            ld_valid = vecs[i].ldv; ld_data = vecs[i].ldd;
            tick();
            idle_inputs();
            exp_cnt++;
            chk($sformatf("vec%0d_we", i), reg_we, vecs[i].exp_we);
            chk($sformatf("vec%0d_wa", i), reg_wa, vecs[i].exp_wa);
            chk($sformatf("vec%0d_wd", i), reg_wd, vecs[i].exp_wd);
            chk($sformatf("vec%0d_cnt", i), retire_cnt, exp_cnt);
            chk($sformatf("vec%0d_ready", i), in_ready, 1);
            chk($sformatf("vec%0d_unexp", i), ld_unexpected, 0);
        end
        tick();
        chk("post_vec_we", reg_we, 0);

        // Waiting byte loads, signed then unsigned
        wait_load("ldwait_s", 1'b1, 32'hFFFF_FF80);
        wait_load("ldwait_u", 1'b0, 32'h0000_0080);

        // Four back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            drive_alu(4'(i + 1), 32'h100 + 32'(i));
            tick();
            exp_cnt++;
            chk($sformatf("b2b%0d_we", i), reg_we, 1);
            chk($sformatf("b2b%0d_wa", i), reg_wa, i + 1);
            chk($sformatf("b2b%0d_wd", i), reg_wd, 32'h100 + 32'(i));
            chk($sformatf("b2b%0d_cnt", i), retire_cnt, exp_cnt);
        end
        idle_inputs();
        tick();
        chk("b2b_we_off", reg_we, 0);
        chk("b2b_wa_hold", reg_wa, 4);

        // Load data with nothing pending
        ld_valid = 1'b1; ld_data = 32'h1111_1111;
        tick();
        idle_inputs();
        chk("unexp_pulse", ld_unexpected, 1);
        chk("unexp_we", reg_we, 0);
        chk("unexp_cnt", retire_cnt, exp_cnt);
        tick();
        chk("unexp_clear", ld_unexpected, 0);

        // Load data alongside an accepted ALU op: op commits, data flagged
        drive_alu(4'd3, 32'h0000_00C3);
        ld_valid = 1'b1;
        tick();
        idle_inputs();
        exp_cnt++;
        chk("unexp_alu_pulse", ld_unexpected, 1);
        chk("unexp_alu_we", reg_we, 1);
        chk("unexp_alu_wd", reg_wd, 32'h0000_00C3);
        chk("unexp_alu_cnt", retire_cnt, exp_cnt);

        // Reset while a load is waiting
        idle_inputs();
        in_valid = 1'b1; in_isWb = 1'b1; in_isLd = 1'b1; in_rd = 4'd14; in_ldSize = 2'd2;
        tick();
        idle_inputs();
        chk("rstld_ready_wait", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("rstld_ready_now", in_ready, 1);
        chk("rstld_we", reg_we, 0);
        chk("rstld_cnt", retire_cnt, exp_cnt);
        tick();
        rst_n = 1'b1;
        ld_valid = 1'b1; ld_data = 32'h2222_2222;
        tick();
        idle_inputs();
        chk("rstld_no_write", reg_we, 0);
        chk("rstld_unexp", ld_unexpected, 1);
        chk("rstld_cnt_after", retire_cnt, 0);

        // 4-bit retire counter wrap
        reset_pulse();
        for (int i = 0; i < 16; i++) begin
            drive_alu(4'd1, 32'(i));
            tick();
            exp_cnt++;
            if (i == 14) chk("wrap_c4_15", retire_cnt4, 15);
        end
        idle_inputs();
        chk("wrap_c4_zero", retire_cnt4, 0);
        chk("wrap_main_16", retire_cnt, exp_cnt);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback_stage.md
# reg_writeback_stage

Registered, parametrised writeback stage for the SimpleRISC pipeline. It accepts one retiring instruction per cycle from the memory-access stage over a valid/ready handshake. It waits for variable-latency load data and applies byte/half/word extraction with sign or zero extension. It then drives the register-file write port, which doubles as the forwarding source, and counts retired instructions.

## Interface
- DATA_W, 32: datapath width; multiple of 16, ≥32.
- REG_AW, 4: register address width.
- LINK_REG, 15: destination index forced for calls.
- PC_INC, 4: return-address increment added to pc on a call.
- CNT_W, 32: retire counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  MA stage presents an instruction.
- in_ready  out  1  stage can accept; combinational, equals (state==IDLE).
- in_isWb  in  1  instruction writes a register.
- in_isLd  in  1  instruction is a load.
- in_isCall  in  1  instruction is a call; writes pc+PC_INC to LINK_REG.
- in_rd  in  REG_AW  destination register.
- in_aluResult  in  DATA_W  ALU result.
- in_pc  in  DATA_W  instruction pc.
- in_ldSize  in  2  0 byte, 1 half, 2 word; 3 treated as word.
- in_ldSigned  in  1  1 sign-extend, 0 zero-extend.
- in_ldOff  in  2  byte offset within the 32-bit word (low address bits).
- ld_valid  in  1  load data valid this cycle.
- ld_data  in  DATA_W  raw load word.
- reg_we  out  1  register-file write enable, registered.
- reg_wa  out  REG_AW  write address, registered.
- reg_wd  out  DATA_W  write data, registered.
- ld_unexpected  out  1  one-cycle pulse, registered: ld_valid seen with no load pending.
- retire_cnt  out  CNT_W  retired instruction count; wraps modulo 2^CNT_W.

## Operation
- State machine has two states, IDLE and WAIT_LD.
- **Accept**: an accept occurs when in_valid && in_ready.
  - On accept, the stage latches isWb, rd, isCall, ldSize, ldSigned, ldOff and the pre-computed non-load result.
- **Result select**, in priority order:
  - isCall: wd = in_pc + PC_INC, truncated to DATA_W; wa = LINK_REG.
  - isLd: wd = extended load value; wa = rd.
  - Otherwise: wd = aluResult; wa = rd.
- **Load extraction**:
  - byte = ld_data[8*ldOff +: 8].
  - half = ld_data[16*ldOff[1] +: 16]; ldOff[0] is ignored.
  - word = ld_data[DATA_W-1:0].
  - The value is extended to DATA_W per ldSigned.
- **IDLE**:
  - Accept of a non-load, or of a load with ld_valid in the same cycle: commit next edge and stay in IDLE.
  - Accept of a load without ld_valid: go to WAIT_LD.
- **WAIT_LD**: in_ready=0.
  - On ld_valid: extract from the latched fields, commit next edge, go to IDLE.
- **Commit**, in the cycle after the commit edge:
  - reg_we = latched isWb; reg_wa and reg_wd as selected.
  - retire_cnt increments by 1 whether or not isWb.
- When no commit occurs, reg_we=0. reg_wa and reg_wd hold their previous values.
- isCall together with isLd is treated as a call: no load wait, and ld_valid is not consumed.
- ld_valid in IDLE without an accepting load, or during an accepting non-load: ld_unexpected=1 next cycle; data is discarded.

## Timing
- **Reset values**: state=IDLE, reg_we=0, reg_wa=0, reg_wd=0, ld_unexpected=0, retire_cnt=0.
  - in_ready=1 immediately after reset is asserted.
- **Latency**: accept at edge N gives reg_we high in cycle N+1.
  - A load whose data arrives k cycles after accept writes in cycle N+k+1.
- **Throughput**: one instruction per cycle when no load waits. Back-to-back accepts give reg_we high on consecutive cycles.
- in_ready falls in the cycle after a waiting load is accepted. It rises in the cycle after ld_valid is sampled in WAIT_LD.
  - A new instruction can therefore be accepted in the cycle after the load commits.
- reg_we is high for exactly one cycle per committed instruction with isWb=1.
- **Reset mid-operation**: reset in WAIT_LD abandons the load without a write. Any commit pending at that edge is dropped.
- **Counter wrap**: retire_cnt at 2^CNT_W-1 plus a commit gives 0.

## Test plan
- Reset with in_valid=1 held → reg_we=0, retire_cnt=0, in_ready=1. After release, accept ALU op rd=3, aluResult=0x1234 → next cycle reg_we=1, reg_wa=3, reg_wd=0x1234, retire_cnt=1.
- Call with pc=0x100, rd=7, isWb=1 → reg_wa=15, reg_wd=0x104.
- Call with isWb=0 → reg_we=0 and retire_cnt still increments.
- Load with ldSize=0, ldSigned=1, ldOff=2, ld_data=0x0080_0000, ld_valid 3 cycles after accept → in_ready=0 for 3 cycles, then reg_wd=0xFFFF_FF80.
- Repeat the same load with ldSigned=0 → reg_wd=0x0000_0080.
- Half load, ldOff=2, ld_data=0x8001_0000, zero-extend, ld_valid in the accept cycle → reg_wd=0x0000_8001, no stall.
- Four back-to-back ALU ops → reg_we high for 4 consecutive cycles.
- ld_valid with no load pending → ld_unexpected pulses for one cycle.
- Reset asserted in WAIT_LD → no write occurs, state returns to IDLE.
- With CNT_W=4: 16 commits → retire_cnt wraps to 0.
